mem_stage_ctrl: RTL



---
 rtl/Uop.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/Uop.sv
// Micro-op payloads passed between the EX, MEM and WB pipeline stages.
package Uop;

  typedef enum logic [2:0] {
    EX_NONE      = 3'd0,
    EX_ILLEGAL   = 3'd1,
    EX_MEM_ALIGN = 3'd2,
    EX_MEM_MISS  = 3'd3
  } ex_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_sz_t;

  typedef struct packed {
    logic    en;
    logic    we;
    mem_sz_t sz;
    logic    signExtend;
  } mem_op_t;

  typedef struct packed {
    ex_t         ex;
    logic [4:0]  rd;
    logic [31:0] rdVal;
    logic [31:0] rs2Val;
    mem_op_t     memOp;
  } execute_t;

  typedef struct packed {
    ex_t         ex;
    logic [4:0]  rd;
    logic [31:0] rdVal;
  } memory_t;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs one data-bus transaction per accepted uop and registers the result for WB.
// Pass-through uops take 1 cycle; bus uops take >= 3 cycles. in_ready only in IDLE with a free output register.
module mem_stage_ctrl
  import Uop::*;
#(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  Uop::execute_t    in_uop,
  output logic             out_valid,
  input  logic             out_ready,
  output Uop::memory_t     out_uop,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [29:0]      dbus_addr,
  output logic [3:0]       dbus_be,
  output logic [31:0]      dbus_wdata,
  input  logic             dbus_gnt,
  input  logic             dbus_rvalid,
  input  logic [31:0]      dbus_rdata,
  input  logic             dbus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  mem_sz_t     sz_q;
  logic        sext_q;
  logic [4:0]  rd_q;

  logic        accept;
  logic        start;
  logic        load_out;
  memory_t     out_nxt;

  logic [1:0]  in_a;
  logic        misaligned;
  logic        pass;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        timeout;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  assign in_a       = in_uop.rdVal[1:0];
  assign misaligned = ((in_uop.memOp.sz == SZ_H) && in_a[0]) ||
                      ((in_uop.memOp.sz == SZ_W) && (in_a != 2'b00));
  assign pass       = (in_uop.ex != EX_NONE) || !in_uop.memOp.en || misaligned;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = in_uop.rs2Val;
    case (in_uop.memOp.sz)
      SZ_B: begin
        be_in    = 4'b0001 << in_a;
        wdata_in = {4{in_uop.rs2Val[7:0]}};
      end
      SZ_H: begin
        be_in    = in_a[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{in_uop.rs2Val[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = in_uop.rs2Val;
      end
    endcase
  end

  assign shifted = dbus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = dbus_rdata;
    case (sz_q)
      SZ_B:    load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: load_data = dbus_rdata;
    endcase
  end

  assign timeout = (WAIT_LIMIT != 0) && ((wait_cnt + 1'b1) == LIMIT);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    start        = 1'b0;
    load_out     = 1'b0;
    out_nxt      = out_uop;
    case (state)
      IDLE: begin
        if (accept) begin
          if (pass) begin
            load_out      = 1'b1;
            out_nxt.ex    = in_uop.ex;
            out_nxt.rd    = in_uop.rd;
            out_nxt.rdVal = in_uop.rdVal;
            if (in_uop.ex == EX_NONE && in_uop.memOp.en && misaligned)
              out_nxt.ex = EX_MEM_ALIGN;
          end else begin
            start     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (flush) begin
          state_nxt = dbus_gnt ? DRAIN : IDLE;
        end else if (dbus_gnt) begin
          state_nxt = RESP;
        end else if (timeout) begin
          state_nxt     = IDLE;
          load_out      = 1'b1;
          out_nxt.ex    = EX_MEM_MISS;
          out_nxt.rd    = rd_q;
          out_nxt.rdVal = addr_q;
        end else if (WAIT_LIMIT != 0) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        // A response arriving in the flush cycle is absorbed here; draining would wait for one that never comes.
        if (flush) begin
          state_nxt = dbus_rvalid ? IDLE : DRAIN;
        end else if (dbus_rvalid) begin
          state_nxt     = IDLE;
          load_out      = 1'b1;
          out_nxt.rd    = rd_q;
          out_nxt.ex    = dbus_err ? EX_MEM_MISS : EX_NONE;
          out_nxt.rdVal = (dbus_err || we_q) ? addr_q : load_data;
        end
      end
      DRAIN: begin
        if (dbus_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_uop   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      sz_q      <= SZ_B;
      sext_q    <= 1'b0;
      rd_q      <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (start) begin
        addr_q  <= in_uop.rdVal;
        we_q    <= in_uop.memOp.we;
        be_q    <= be_in;
        wdata_q <= wdata_in;
        sz_q    <= in_uop.memOp.sz;
        sext_q  <= in_uop.memOp.signExtend;
        rd_q    <= in_uop.rd;
      end
      if (load_out) begin
        out_valid <= 1'b1;
        out_uop   <= out_nxt;
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbus_req   = (state == REQ);
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q[31:2];
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

endmodule
